mux_scan_ctrl: RTL and testbench

Upstream controller for the 8-to-1 mux stage (`mux_8_1`). It accepts an 8-bit word over a valid/ready handshake, holds it on the mux data inputs, and steps the 3-bit select from 0 to 7, so the mux output serialises the word LSB-first. Each select value is held for a programmable number of cycles. Frame markers tell downstream logic where each serial frame starts and ends.

---
 rtl/mux_pkg.sv | 13 +
 rtl/mux_scan_ctrl_if.sv | 25 ++
 rtl/mux_8_1.sv | 12 +
 rtl/mux_scan_ctrl.sv | 95 +++++++++
 tb/tb_mux_scan_ctrl.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/mux_pkg.sv
// Shared widths and state encoding for the 8:1 mux stage and its scan controller.
package mux_pkg;

  localparam int unsigned NUM_IN = 8;
  localparam int unsigned SEL_W  = 3;
  localparam int unsigned HOLD_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_t;

endpackage

// File: rtl/mux_scan_ctrl_if.sv
// Word handshake from the source plus the mux-side slot bus driven by the scan controller.
interface mux_scan_ctrl_if
  import mux_pkg::*;
;
  logic [NUM_IN-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              abort;
  logic [NUM_IN-1:0] i;
  logic [SEL_W-1:0]  s;
  logic              sel_valid;
  logic              frame_start;
  logic              frame_done;

  modport master (
    output in_data, in_valid, abort,
    input  in_ready, i, s, sel_valid, frame_start, frame_done
  );

  modport slave (
    input  in_data, in_valid, abort,
    output in_ready, i, s, sel_valid, frame_start, frame_done
  );

endinterface

// File: rtl/mux_8_1.sv
// Plain 8-to-1 combinational mux; select s picks bit i[s].
module mux_8_1
  import mux_pkg::*;
(
  input  logic [NUM_IN-1:0] i,
  input  logic [SEL_W-1:0]  s,
  output logic              y
);

  assign y = i[s];

endmodule

// File: rtl/mux_scan_ctrl.sv
// Accepts a word, holds it on the mux inputs and steps the select 0..7,
// each slot lasting HOLD_CYCLES cycles, with frame start/done markers.
module mux_scan_ctrl
  import mux_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 1
) (
  input logic            clk,
  input logic            rst_n,
  mux_scan_ctrl_if.slave bus
);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [SEL_W-1:0]  SEL_LAST  = SEL_W'(NUM_IN - 1);

  scan_state_t       state_q, state_d;
  logic [NUM_IN-1:0] data_q, data_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [HOLD_W-1:0] hold_q, hold_d;

  logic slot_end_c;
  logic last_c;
  logic in_ready_c;
  logic accept_c;

  assign slot_end_c = (hold_q == HOLD_LAST);
  assign last_c     = (state_q == SCAN) && (sel_q == SEL_LAST) && slot_end_c;
  assign in_ready_c = !bus.abort && ((state_q == IDLE) || last_c);
  assign accept_c   = in_ready_c && bus.in_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      sel_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      hold_q  <= hold_d;
    end
  end

  // Next state; a reload in the last cycle keeps frames back-to-back, abort overrides everything.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
    hold_d  = hold_q;

    case (state_q)
      IDLE: begin
        if (accept_c) begin
          data_d  = bus.in_data;
          sel_d   = '0;
          hold_d  = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (last_c) begin
          sel_d  = '0;
          hold_d = '0;
          if (accept_c) begin
            data_d  = bus.in_data;
            state_d = SCAN;
          end else begin
            state_d = IDLE;
          end
        end else if (slot_end_c) begin
          hold_d = '0;
          sel_d  = sel_q + SEL_W'(1);
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (bus.abort) begin
      state_d = IDLE;
      sel_d   = '0;
      hold_d  = '0;
    end
  end

  assign bus.in_ready    = in_ready_c;
  assign bus.i           = data_q;
  assign bus.s           = sel_q;
  assign bus.sel_valid   = (state_q == SCAN);
  assign bus.frame_start = (state_q == SCAN) && (sel_q == '0) && (hold_q == '0);
  assign bus.frame_done  = last_c;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl driving mux_8_1: per-cycle vector table at H=1
// plus hand sequences for H=3 slot hold and asynchronous reset mid-frame.
module tb_mux_scan_ctrl;

  typedef struct {
    logic       in_valid;
    logic [7:0] in_data;
    logic       abort;
    logic       rdy;
    logic       sv;
    logic [2:0] s;
    logic [7:0] iw;
    logic       fs;
    logic       fd;
  } vec_t;

  logic clk;
  logic rst_n;
  logic y1, y2;
  int   total;
  int   passed;
  vec_t vecs[$];

  mux_scan_ctrl_if bus1();
  mux_scan_ctrl_if bus2();

  mux_scan_ctrl #(.HOLD_CYCLES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
  mux_scan_ctrl #(.HOLD_CYCLES(3)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2.slave));

  mux_8_1 mux1 (.i(bus1.i), .s(bus1.s), .y(y1));
  mux_8_1 mux2 (.i(bus2.i), .s(bus2.s), .y(y2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int idx, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s[%0d] got=%0h exp=%0h", nm, idx, got, exp);
  endtask

  task automatic add(input logic v, input logic [7:0] d, input logic a, input logic rdy,
                     input logic sv, input logic [2:0] s, input logic [7:0] iw,
                     input logic fs, input logic fd);
    vec_t r;
    r.in_valid = v; r.in_data = d; r.abort = a; r.rdy = rdy; r.sv = sv;
    r.s = s; r.iw = iw; r.fs = fs; r.fd = fd;
    vecs.push_back(r);
  endtask

  // Mid-frame slots first..last of word iw, with the source offering (v, d) meanwhile.
  task automatic add_mid(input logic [7:0] iw, input logic v, input logic [7:0] d,
                         input int first, input int last_s);
    for (int k = first; k <= last_s; k++)
      add(v, d, 1'b0, 1'b0, 1'b1, 3'(k), iw, 1'b0, 1'b0);
  endtask

  task automatic check_bus1(input string tag, input int idx, input vec_t e);
    logic [7:0] ew;
    ew = e.iw;
    chk({tag, ".in_ready"},  idx, 8'(bus1.in_ready),    8'(e.rdy));
    chk({tag, ".sel_valid"}, idx, 8'(bus1.sel_valid),   8'(e.sv));
    chk({tag, ".s"},         idx, 8'(bus1.s),           8'(e.s));
    chk({tag, ".i"},         idx, bus1.i,               e.iw);
    chk({tag, ".fstart"},    idx, 8'(bus1.frame_start), 8'(e.fs));
    chk({tag, ".fdone"},     idx, 8'(bus1.frame_done),  8'(e.fd));
    chk({tag, ".y"},         idx, 8'(y1),               8'(ew[e.s]));
  endtask

  initial begin
    vec_t       e;
    logic [7:0] w;
    logic [2:0] es;
    total  = 0;
    passed = 0;

    // Basic frame 0xA5
    add(1, 8'hA5, 0, 1, 0, 0, 8'h00, 0, 0);
    add(0, 8'h00, 0, 0, 1, 0, 8'hA5, 1, 0);
    add_mid(8'hA5, 0, 8'h00, 1, 6);
    add(0, 8'h00, 0, 1, 1, 7, 8'hA5, 0, 1);
    add(0, 8'h00, 0, 1, 0, 0, 8'hA5, 0, 0);
    // Back-to-back 0x01 then 0xFF
    add(1, 8'h01, 0, 1, 0, 0, 8'hA5, 0, 0);
    add(1, 8'hFF, 0, 0, 1, 0, 8'h01, 1, 0);
    add_mid(8'h01, 1, 8'hFF, 1, 6);
    add(1, 8'hFF, 0, 1, 1, 7, 8'h01, 0, 1);
    add(0, 8'h00, 0, 0, 1, 0, 8'hFF, 1, 0);
    add_mid(8'hFF, 0, 8'h00, 1, 6);
    add(0, 8'h00, 0, 1, 1, 7, 8'hFF, 0, 1);
    add(0, 8'h00, 0, 1, 0, 0, 8'hFF, 0, 0);
    // Abort at s=4 with a word pending
    add(1, 8'h96, 0, 1, 0, 0, 8'hFF, 0, 0);
    add(0, 8'h00, 0, 0, 1, 0, 8'h96, 1, 0);
    add_mid(8'h96, 0, 8'h00, 1, 3);
    add(1, 8'h5A, 1, 0, 1, 4, 8'h96, 0, 0);
    add(1, 8'h5A, 0, 1, 0, 0, 8'h96, 0, 0);
    add(0, 8'h00, 0, 0, 1, 0, 8'h5A, 1, 0);
    add_mid(8'h5A, 0, 8'h00, 1, 6);
    add(0, 8'h00, 0, 1, 1, 7, 8'h5A, 0, 1);
    add(0, 8'h00, 0, 1, 0, 0, 8'h5A, 0, 0);
    // Backpressure: 0x3C offered through the whole 0xC3 frame
    add(1, 8'hC3, 0, 1, 0, 0, 8'h5A, 0, 0);
    add(1, 8'h3C, 0, 0, 1, 0, 8'hC3, 1, 0);
    add_mid(8'hC3, 1, 8'h3C, 1, 6);
    add(1, 8'h3C, 0, 1, 1, 7, 8'hC3, 0, 1);
    add(0, 8'h00, 0, 0, 1, 0, 8'h3C, 1, 0);
    add_mid(8'h3C, 0, 8'h00, 1, 6);
    add(0, 8'h00, 0, 1, 1, 7, 8'h3C, 0, 1);
    add(0, 8'h00, 0, 1, 0, 0, 8'h3C, 0, 0);
    // Abort while idle blocks acceptance
    add(1, 8'h77, 1, 0, 0, 0, 8'h3C, 0, 0);
    add(0, 8'h00, 0, 1, 0, 0, 8'h3C, 0, 0);

    rst_n = 1'b0;
    bus1.in_valid = 1'b0; bus1.in_data = 8'h00; bus1.abort = 1'b0;
    bus2.in_valid = 1'b0; bus2.in_data = 8'h00; bus2.abort = 1'b0;

    // Reset values
    #12;
    e = '{in_valid: 0, in_data: 0, abort: 0, rdy: 1, sv: 0, s: 0, iw: 8'h00, fs: 0, fd: 0};
    check_bus1("reset", 0, e);
    @(negedge clk);
    rst_n = 1'b1;

    // Table at H=1: drive on the falling edge, sample 1 ns later, state advances on the rising edge.
    for (int n = 0; n < vecs.size(); n++) begin
      if (n != 0) @(negedge clk);
      bus1.in_valid = vecs[n].in_valid;
      bus1.in_data  = vecs[n].in_data;
      bus1.abort    = vecs[n].abort;
      #1;
      check_bus1("vec", n, vecs[n]);
    end
    @(negedge clk);
    bus1.in_valid = 1'b0;
    bus1.abort    = 1'b0;

    // H=3: 0x0F, each select held 3 cycles, 24-cycle frame
    w = 8'h0F;
    bus2.in_valid = 1'b1;
    bus2.in_data  = w;
    #1;
    chk("h3.accept_rdy", 0, 8'(bus2.in_ready), 8'd1);
    for (int c = 1; c <= 25; c++) begin
      @(negedge clk);
      bus2.in_valid = 1'b0;
      #1;
      es = (c <= 24) ? 3'((c - 1) / 3) : 3'd0;
      chk("h3.s",         c, 8'(bus2.s),           8'(es));
      chk("h3.sel_valid", c, 8'(bus2.sel_valid),   8'(c <= 24));
      chk("h3.fstart",    c, 8'(bus2.frame_start), 8'(c == 1));
      chk("h3.fdone",     c, 8'(bus2.frame_done),  8'(c == 24));
      chk("h3.in_ready",  c, 8'(bus2.in_ready),    8'(c >= 24));
      chk("h3.i",         c, bus2.i,               w);
      chk("h3.y",         c, 8'(y2),               8'(w[es]));
    end

    // Asynchronous reset at s=5 of a 0xE7 frame
    @(negedge clk);
    bus1.in_valid = 1'b1;
    bus1.in_data  = 8'hE7;
    @(negedge clk);
    bus1.in_valid = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    chk("rst.pre_s", 0, 8'(bus1.s), 8'd5);
    chk("rst.pre_i", 0, bus1.i,      8'hE7);
    #2;
    rst_n = 1'b0;
    #1;
    e = '{in_valid: 0, in_data: 0, abort: 0, rdy: 1, sv: 0, s: 0, iw: 8'h00, fs: 0, fd: 0};
    check_bus1("rst.async", 0, e);
    bus1.in_valid = 1'b1;
    bus1.in_data  = 8'h81;
    @(posedge clk);
    #1;
    chk("rst.no_accept", 0, 8'(bus1.sel_valid), 8'd0);
    chk("rst.no_load",   0, bus1.i,             8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst.rel_rdy", 0, 8'(bus1.in_ready), 8'd1);
    @(negedge clk);
    bus1.in_valid = 1'b0;
    #1;
    e = '{in_valid: 0, in_data: 0, abort: 0, rdy: 0, sv: 1, s: 0, iw: 8'h81, fs: 1, fd: 0};
    check_bus1("rst.newframe", 0, e);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
